// File: rtl/clk_en_scheduler_if.sv
// Configuration handshake between a game-logic master and the clock-enable scheduler:
// a new game-tick divide ratio is offered with cfg_valid and taken when cfg_ready is high.
interface clk_en_scheduler_if #(
    parameter int TICK_W = 24
) ();
    logic              cfg_valid;
    logic [TICK_W-1:0] cfg_div;
    logic              cfg_ready;

    modport master (output cfg_valid, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_en_scheduler.sv
// Clock-enable scheduler: 1-in-PIX_DIV pixel enable plus a runtime-programmable game tick.
// Optional legacy divided pixel clock output pix_clk under macro CLK_EN_SCHED_PIXCLK_OUT_EN.
module clk_en_scheduler #(
    parameter int PIX_DIV      = 4,
    parameter int TICK_W       = 24,
    parameter int TICK_DIV_RST = 1666667,
    parameter int FCNT_W       = 16
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    clk_en_scheduler_if.slave cfg,
    output logic              pix_ce,
    output logic              game_tick,
    output logic [FCNT_W-1:0] frame_count,
    output logic              busy
`ifdef CLK_EN_SCHED_PIXCLK_OUT_EN
    ,
    output logic              pix_clk
`endif
);
    localparam int                 PIX_W    = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
    localparam logic [PIX_W-1:0]   PIX_LAST = PIX_W'(PIX_DIV - 1);
    localparam logic [PIX_W-1:0]   PIX_ONE  = PIX_W'(1);
    localparam logic [TICK_W-1:0]  TICK_ONE = TICK_W'(1);
    localparam logic [TICK_W-1:0]  DIV_RST  = TICK_W'(TICK_DIV_RST);
    localparam logic [FCNT_W-1:0]  FCNT_ONE = FCNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    state_t              state_r;
    logic [PIX_W-1:0]    pix_cnt_r;
    logic [TICK_W-1:0]   tick_cnt_r;
    logic [TICK_W-1:0]   div_reg_r;
    logic [TICK_W-1:0]   pend_div_r;
    logic [FCNT_W-1:0]   frame_cnt_r;

    logic [PIX_W-1:0]    pix_next_s;
    logic                ready_s;
    logic                accept_s;
    logic [TICK_W-1:0]   cfg_n_s;
    logic                terminal_s;
    logic                tick_s;

    // Next-state helpers decoded purely from registers and the handshake inputs
    always_comb begin
        pix_next_s = (pix_cnt_r == PIX_LAST) ? '0 : (pix_cnt_r + PIX_ONE);
        ready_s    = (state_r != ST_PEND);
        accept_s   = cfg.cfg_valid && ready_s;
        // A zero ratio would never reach terminal count, so it is treated as 1
        cfg_n_s    = (cfg.cfg_div == '0) ? TICK_ONE : cfg.cfg_div;
        terminal_s = (tick_cnt_r == (div_reg_r - TICK_ONE));
        tick_s     = (state_r != ST_IDLE) && terminal_s;
    end

    // Free-running pixel phase counter, independent of enable
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pix_cnt_r <= '0;
        end else begin
            pix_cnt_r <= pix_next_s;
        end
    end

`ifdef CLK_EN_SCHED_PIXCLK_OUT_EN
    logic pix_clk_r;

    // Square wave tracking the pixel counter MSB, registered from its next value
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pix_clk_r <= 1'b0;
        end else begin
            pix_clk_r <= pix_next_s[PIX_W-1];
        end
    end

    assign pix_clk = pix_clk_r;
`endif

    // Game-tick FSM: divider, pending reconfiguration and frame counter
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            tick_cnt_r  <= '0;
            div_reg_r   <= DIV_RST;
            pend_div_r  <= DIV_RST;
            frame_cnt_r <= '0;
        end else begin
            if (tick_s) begin
                frame_cnt_r <= frame_cnt_r + FCNT_ONE;
            end
            case (state_r)
                ST_IDLE: begin
                    tick_cnt_r <= '0;
                    if (accept_s) begin
                        div_reg_r <= cfg_n_s;
                    end
                    if (enable) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        // A config taken while stopping is applied directly, not lost
                        state_r    <= ST_IDLE;
                        tick_cnt_r <= '0;
                        if (accept_s) begin
                            div_reg_r <= cfg_n_s;
                        end
                    end else if (accept_s && terminal_s) begin
                        div_reg_r  <= cfg_n_s;
                        tick_cnt_r <= '0;
                    end else if (accept_s) begin
                        pend_div_r <= cfg_n_s;
                        tick_cnt_r <= tick_cnt_r + TICK_ONE;
                        state_r    <= ST_PEND;
                    end else if (terminal_s) begin
                        tick_cnt_r <= '0;
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TICK_ONE;
                    end
                end
                ST_PEND: begin
                    if (!enable) begin
                        div_reg_r  <= pend_div_r;
                        tick_cnt_r <= '0;
                        state_r    <= ST_IDLE;
                    end else if (terminal_s) begin
                        div_reg_r  <= pend_div_r;
                        tick_cnt_r <= '0;
                        state_r    <= ST_RUN;
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TICK_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    tick_cnt_r <= '0;
                end
            endcase
        end
    end

    assign pix_ce        = (pix_cnt_r == PIX_LAST);
    assign game_tick     = tick_s;
    assign cfg.cfg_ready = ready_s;
    assign busy          = (state_r != ST_IDLE);
    assign frame_count   = frame_cnt_r;

endmodule

// File: tb/tb_clk_en_scheduler.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs from a behavioural model,
// a negedge monitor pops and compares them against the scheduler outputs.
module tb_clk_en_scheduler;
    localparam int PIX_DIV      = 4;
    localparam int TICK_W       = 24;
    localparam int TICK_DIV_RST = 1666667;
    localparam int FCNT_W       = 16;

    typedef struct {
        logic        pix;
        logic        tick;
        logic        ready;
        logic        bsy;
        logic [15:0] frames;
    } exp_t;

    logic              clk_in = 1'b0;
    logic              reset  = 1'b1;
    logic              enable = 1'b0;
    logic              pix_ce;
    logic              game_tick;
    logic [FCNT_W-1:0] frame_count;
    logic              busy;

    clk_en_scheduler_if #(.TICK_W(TICK_W)) cfg_bus ();

    clk_en_scheduler #(
        .PIX_DIV(PIX_DIV), .TICK_W(TICK_W), .TICK_DIV_RST(TICK_DIV_RST), .FCNT_W(FCNT_W)
    ) dut (
        .clk_in(clk_in), .reset(reset), .enable(enable), .cfg(cfg_bus),
        .pix_ce(pix_ce), .game_tick(game_tick), .frame_count(frame_count), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   count_pix = 1'b0;
    int   pix_seen  = 0;

    // Behavioural model: period/remaining-cycles view of the tick, global cycle count for pixels
    int cyc;
    bit run, pend;
    int period, pend_val, left, frames;

    task automatic m_reset();
        cyc = 0; run = 1'b0; pend = 1'b0;
        period = TICK_DIV_RST; pend_val = TICK_DIV_RST; left = TICK_DIV_RST; frames = 0;
    endtask

    function automatic exp_t m_expect();
        exp_t e;
        e.pix    = ((cyc % PIX_DIV) == PIX_DIV - 1);
        e.tick   = run && (left == 1);
        e.ready  = !pend;
        e.bsy    = run;
        e.frames = 16'(frames);
        return e;
    endfunction

    task automatic m_advance(input bit en, input bit val, input int div);
        int n;
        bit acc, tk;
        n   = (div == 0) ? 1 : div;
        acc = val && !pend;
        tk  = run && (left == 1);
        if (tk) frames = (frames + 1) % 65536;
        cyc++;
        if (!run) begin
            if (acc) period = n;
            if (en) begin run = 1'b1; left = period; end
        end else if (!pend) begin
            if (!en) begin
                run = 1'b0;
                if (acc) period = n;
            end else if (acc && tk) begin
                period = n; left = period;
            end else if (acc) begin
                pend = 1'b1; pend_val = n; left = left - 1;
            end else begin
                left = tk ? period : left - 1;
            end
        end else begin
            if (!en) begin
                period = pend_val; pend = 1'b0; run = 1'b0;
            end else if (tk) begin
                period = pend_val; pend = 1'b0; left = period;
            end else begin
                left = left - 1;
            end
        end
    endtask

    // One clock cycle of stimulus; a newly asserted reset lands mid-cycle to exercise the async path
    task automatic step(input bit rst_v, input bit en_v, input bit val_v, input int div_v);
        @(posedge clk_in);
        #1;
        enable = en_v;
        cfg_bus.cfg_valid = val_v;
        cfg_bus.cfg_div   = TICK_W'(div_v);
        if (rst_v && !reset) #1;
        reset = rst_v;
        if (rst_v) m_reset();
        exp_q.push_back(m_expect());
        if (!rst_v) m_advance(en_v, val_v, div_v);
    endtask

    task automatic idle_steps(input int n, input bit en_v);
        for (int i = 0; i < n; i++) step(1'b0, en_v, 1'b0, 0);
    endtask

    // Monitor: compare every presented cycle against the oldest queued expectation
    exp_t me;
    always @(negedge clk_in) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            n_checks++;
            if ({pix_ce, game_tick, cfg_bus.cfg_ready, busy, frame_count} !==
                {me.pix, me.tick, me.ready, me.bsy, me.frames}) begin
                n_fail++;
                $display("FAIL outputs t=%0t got pix_ce=%b game_tick=%b cfg_ready=%b busy=%b frame_count=%h, want %b %b %b %b %h",
                         $time, pix_ce, game_tick, cfg_bus.cfg_ready, busy, frame_count,
                         me.pix, me.tick, me.ready, me.bsy, me.frames);
            end
            if (count_pix && pix_ce === 1'b1) pix_seen++;
        end
    end

    initial begin
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_div   = '0;
        m_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0);

        // Reset release: 40 cycles of pixel enables, no game ticks
        count_pix = 1'b1;
        idle_steps(40, 1'b0);
        @(negedge clk_in); #1;
        count_pix = 1'b0;
        n_checks++;
        if (pix_seen != 10) begin
            n_fail++;
            $display("FAIL pix_count got %0d want 10", pix_seen);
        end

        // N=5 loaded in IDLE, then run: four ticks expected
        step(1'b0, 1'b0, 1'b1, 5);
        idle_steps(23, 1'b1);
        @(negedge clk_in); #1;
        n_checks++;
        if (frame_count !== 16'd4) begin
            n_fail++;
            $display("FAIL frame_count_n5 got %0d want 4", frame_count);
        end
        idle_steps(2, 1'b0);

        // N=10, reconfigure to 4 at tick_cnt=3 (PEND for six cycles)
        step(1'b0, 1'b0, 1'b1, 10);
        idle_steps(4, 1'b1);
        step(1'b0, 1'b1, 1'b1, 4);
        idle_steps(20, 1'b1);
        idle_steps(2, 1'b0);

        // cfg_div=0 with enable: tick every cycle, long enough to wrap frame_count
        step(1'b0, 1'b1, 1'b1, 0);
        idle_steps(65545, 1'b1);
        idle_steps(2, 1'b0);

        // PEND with pend_div=7, drop enable, then re-enable
        step(1'b0, 1'b0, 1'b1, 10);
        idle_steps(3, 1'b1);
        step(1'b0, 1'b1, 1'b1, 7);
        idle_steps(2, 1'b1);
        idle_steps(3, 1'b0);
        idle_steps(16, 1'b1);

        // Async reset in the middle of PEND
        idle_steps(2, 1'b0);
        step(1'b0, 1'b0, 1'b1, 10);
        idle_steps(3, 1'b1);
        step(1'b0, 1'b1, 1'b1, 3);
        idle_steps(2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 0);
        idle_steps(12, 1'b1);
        idle_steps(2, 1'b0);

        // Randomized traffic with small ratios so terminal-count collisions occur
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                step(1'b1, 1'b0, 1'b0, 0);
            end else begin
                step(1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0),
                     int'($urandom_range(0, 9)));
            end
        end
        idle_steps(4, 1'b0);

        @(negedge clk_in); #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
